// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_ERROR
    } load_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-word stream into the loader: valid/ready handshake with a last marker.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);

endinterface

// File: rtl/imem_loader_csum.sv
// Wrapping-sum accumulator over the data words of one load, compared against the trailing checksum word.
module loader_csum
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] chk,
    output logic              match
);

    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + data;
        end
    end

    assign match = (sum == chk);

endmodule

// File: rtl/imem_loader.sv
// Streams instruction words into IMEM and holds the pipeline in reset until the load completes.
// Build option: IMEM_LOADER_CHECKSUM_EN treats the in_last word as a checksum instead of an instruction.
//
// state    | meaning
// ST_IDLE  | waiting for load_req, pipeline held in reset
// ST_LOAD  | accepting words, writing consecutive IMEM slots
// ST_RUN   | load committed, pipeline released
// ST_ERROR | overflow or checksum mismatch, pipeline held until load_req
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    imem_loader_if.slave      in_bus,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    load_state_t state, state_next;
    logic        hs, full, write_en, err_set;
    logic        in_ready_d, cpu_run_d;

    assign hs   = in_bus.in_valid & in_bus.in_ready;
    assign full = (word_count == FULL);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic csum_match;

    loader_csum #(.DATA_W(DATA_W)) u_csum (
        .clk   (clk),
        .rst   (rst),
        .clr   (load_req),
        .add   (write_en),
        .data  (in_bus.in_data),
        .chk   (in_bus.in_data),
        .match (csum_match)
    );

    // The checksum word never occupies a slot, so it cannot overflow.
    assign write_en = hs & ~load_req & ~full & ~in_bus.in_last;
    assign err_set  = hs & ~load_req &
                      ((full & ~in_bus.in_last) | (in_bus.in_last & ~csum_match));
`else
    assign write_en = hs & ~load_req & ~full;
    assign err_set  = hs & ~load_req & full;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (load_req) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_req)                     state_next = ST_LOAD;
                else if (err_set)                 state_next = ST_ERROR;
                else if (hs && in_bus.in_last)    state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // cpu_run only rises after a full cycle in RUN, so the last write lands before fetch.
    always_comb begin
        in_ready_d = (state_next == ST_LOAD);
        cpu_run_d  = (state == ST_RUN) && (state_next == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_bus.in_ready <= 1'b0;
            cpu_run         <= 1'b0;
            cpu_rst         <= 1'b1;
        end else begin
            in_bus.in_ready <= in_ready_d;
            cpu_run         <= cpu_run_d;
            cpu_rst         <= ~cpu_run_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (load_req) begin
                word_count <= '0;
                err        <= 1'b0;
            end else begin
                if (write_en) begin
                    mem_we     <= 1'b1;
                    mem_addr   <= {{(30-ADDR_W){1'b0}}, word_count[ADDR_W-1:0], 2'b00};
                    mem_wdata  <= in_bus.in_data;
                    word_count <= word_count + ONE;
                end
                if (err_set) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader: a full-size instance and a 4-word instance for overflow.
module tb_imem_loader;

    localparam logic [31:0] W0 = 32'h2008_0005;
    localparam logic [31:0] W1 = 32'h2009_0003;
    localparam logic [31:0] W2 = 32'h0109_5020;
    localparam logic [31:0] W3 = 32'hAC0A_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic        load_req2 = 1'b0;

    logic        mem_we, cpu_rst, cpu_run, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [8:0]  word_count;
    logic        mem_we2, cpu_rst2, cpu_run2, err2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic [2:0]  word_count2;

    int n_pass = 0;
    int n_total = 0;
    int wr_cnt1 = 0;
    int wr_cnt2 = 0;

    imem_loader_if #(.DATA_W(32)) bus1 ();
    imem_loader_if #(.DATA_W(32)) bus2 ();

    imem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .in_bus(bus1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .cpu_run(cpu_run), .word_count(word_count), .err(err)
    );

    imem_loader #(.ADDR_W(2), .DATA_W(32)) dut2 (
        .clk(clk), .rst(rst), .load_req(load_req2), .in_bus(bus2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .cpu_rst(cpu_rst2), .cpu_run(cpu_run2), .word_count(word_count2), .err(err2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we)  wr_cnt1++;
        if (mem_we2) wr_cnt2++;
    end

    typedef struct {
        logic        rst;
        logic        lr;
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic        crst;
        logic        run;
        int          wc;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic r, logic lr, logic v, logic [31:0] d, logic l,
                                 logic rdy, logic we, logic [31:0] addr, logic crst,
                                 logic run, int wc, logic e);
        vec_t t;
        t.rst = r; t.lr = lr; t.v = v; t.d = d; t.l = l;
        t.rdy = rdy; t.we = we; t.addr = addr; t.crst = crst; t.run = run;
        t.wc = wc; t.err = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step1(input logic lr, input logic v, input logic [31:0] d, input logic l);
        load_req = lr; bus1.in_valid = v; bus1.in_data = d; bus1.in_last = l;
        @(posedge clk); #1;
    endtask

    task automatic step2(input logic lr, input logic v, input logic [31:0] d, input logic l);
        load_req2 = lr; bus2.in_valid = v; bus2.in_data = d; bus2.in_last = l;
        @(posedge clk); #1;
    endtask

    task automatic chk1(input string tag, input logic rdy, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic crst, input logic run,
                        input int wc, input logic e);
        chk({tag, " in_ready"}, 32'(bus1.in_ready), 32'(rdy));
        chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
        if (we) begin
            chk({tag, " mem_addr"}, mem_addr, addr);
            chk({tag, " mem_wdata"}, mem_wdata, wdata);
        end
        chk({tag, " cpu_rst"}, 32'(cpu_rst), 32'(crst));
        chk({tag, " cpu_run"}, 32'(cpu_run), 32'(run));
        chk({tag, " word_count"}, 32'(word_count), 32'(wc));
        chk({tag, " err"}, 32'(err), 32'(e));
    endtask

    initial begin
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset2 cpu_rst", 32'(cpu_rst2), 32'd1);
        rst = 1'b0;

`ifndef IMEM_LOADER_CHECKSUM_EN
        // rst lr v data last | rdy we addr crst run wc err
        vecs.push_back(mkv(0,1,0,0,0,            1,0,32'h0,1,0,0,0));
        vecs.push_back(mkv(0,0,1,W0,0,           1,1,32'h0,1,0,1,0));
        vecs.push_back(mkv(0,0,1,W1,0,           1,1,32'h4,1,0,2,0));
        vecs.push_back(mkv(0,0,1,W2,0,           1,1,32'h8,1,0,3,0));
        vecs.push_back(mkv(0,0,1,W3,1,           0,1,32'hC,1,0,4,0));
        vecs.push_back(mkv(0,0,0,0,0,            0,0,32'h0,0,1,4,0));
        vecs.push_back(mkv(0,0,0,0,0,            0,0,32'h0,0,1,4,0));
        vecs.push_back(mkv(0,1,0,0,0,            1,0,32'h0,1,0,0,0));
        vecs.push_back(mkv(0,0,1,32'hDEADBEEF,0, 1,1,32'h0,1,0,1,0));
        vecs.push_back(mkv(0,0,1,32'h12345678,1, 0,1,32'h4,1,0,2,0));
        vecs.push_back(mkv(0,0,0,0,0,            0,0,32'h0,0,1,2,0));
        vecs.push_back(mkv(0,1,0,0,0,            1,0,32'h0,1,0,0,0));
        vecs.push_back(mkv(0,0,1,W0,0,           1,1,32'h0,1,0,1,0));
        vecs.push_back(mkv(0,0,0,0,0,            1,0,32'h0,1,0,1,0));
        vecs.push_back(mkv(0,0,1,W1,0,           1,1,32'h4,1,0,2,0));
        vecs.push_back(mkv(0,0,0,0,0,            1,0,32'h0,1,0,2,0));
        vecs.push_back(mkv(0,0,1,W2,0,           1,1,32'h8,1,0,3,0));
        vecs.push_back(mkv(0,0,0,0,0,            1,0,32'h0,1,0,3,0));
        vecs.push_back(mkv(0,0,1,W3,1,           0,1,32'hC,1,0,4,0));
        vecs.push_back(mkv(0,0,0,0,0,            0,0,32'h0,0,1,4,0));
        vecs.push_back(mkv(0,1,0,0,0,            1,0,32'h0,1,0,0,0));
        vecs.push_back(mkv(0,0,1,W0,0,           1,1,32'h0,1,0,1,0));
        vecs.push_back(mkv(0,1,1,32'hBAD0BAD0,0, 1,0,32'h0,1,0,0,0));
        vecs.push_back(mkv(0,0,1,W1,0,           1,1,32'h0,1,0,1,0));
        vecs.push_back(mkv(0,0,1,W2,0,           1,1,32'h4,1,0,2,0));
        vecs.push_back(mkv(1,0,1,W3,0,           0,0,32'h0,1,0,0,0));
        vecs.push_back(mkv(0,0,1,W3,0,           0,0,32'h0,1,0,0,0));
        vecs.push_back(mkv(0,0,1,W3,1,           0,0,32'h0,1,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            step1(vecs[i].lr, vecs[i].v, vecs[i].d, vecs[i].l);
            chk1($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].d,
                 vecs[i].crst, vecs[i].run, vecs[i].wc, vecs[i].err);
        end
        rst = 1'b0;
        step1(0, 0, 0, 0);
`else
        // Matching checksum: 1+2+3 = 6.
        step1(1, 0, 0, 0);
        wr_cnt1 = 0;
        step1(0, 1, 32'd1, 0); chk1("cs1 w0", 1, 1, 32'h0, 32'd1, 1, 0, 1, 0);
        step1(0, 1, 32'd2, 0); chk1("cs1 w1", 1, 1, 32'h4, 32'd2, 1, 0, 2, 0);
        step1(0, 1, 32'd3, 0); chk1("cs1 w2", 1, 1, 32'h8, 32'd3, 1, 0, 3, 0);
        step1(0, 1, 32'd6, 1); chk1("cs1 last", 0, 0, 32'h0, 32'd0, 1, 0, 3, 0);
        step1(0, 0, 0, 0);     chk1("cs1 run", 0, 0, 32'h0, 32'd0, 0, 1, 3, 0);
        chk("cs1 writes", 32'(wr_cnt1), 32'd3);
        // Mismatching checksum.
        step1(1, 0, 0, 0);     chk1("cs2 req", 1, 0, 32'h0, 32'd0, 1, 0, 0, 0);
        wr_cnt1 = 0;
        step1(0, 1, 32'd1, 0);
        step1(0, 1, 32'd2, 0);
        step1(0, 1, 32'd3, 0);
        step1(0, 1, 32'd7, 1); chk1("cs2 last", 0, 0, 32'h0, 32'd0, 1, 0, 3, 1);
        step1(0, 0, 0, 0);     chk1("cs2 hold", 0, 0, 32'h0, 32'd0, 1, 0, 3, 1);
        step1(0, 1, 32'd9, 0); chk1("cs2 stay", 0, 0, 32'h0, 32'd0, 1, 0, 3, 1);
        step1(0, 0, 0, 0);
        chk("cs2 writes", 32'(wr_cnt1), 32'd3);
`endif

        // Overflow on the 4-word instance: 5 words, no in_last.
        step2(1, 0, 0, 0);
        chk("ovf req in_ready", 32'(bus2.in_ready), 32'd1);
        wr_cnt2 = 0;
        for (int k = 0; k < 4; k++) begin
            step2(0, 1, 32'h100 + 32'(k), 0);
            chk($sformatf("ovf w%0d mem_we", k), 32'(mem_we2), 32'd1);
            chk($sformatf("ovf w%0d mem_addr", k), mem_addr2, 32'(k) << 2);
            chk($sformatf("ovf w%0d mem_wdata", k), mem_wdata2, 32'h100 + 32'(k));
        end
        step2(0, 1, 32'h1FF, 0);
        chk("ovf 5th mem_we", 32'(mem_we2), 32'd0);
        chk("ovf err", 32'(err2), 32'd1);
        chk("ovf cpu_rst", 32'(cpu_rst2), 32'd1);
        chk("ovf in_ready", 32'(bus2.in_ready), 32'd0);
        chk("ovf word_count", 32'(word_count2), 32'd4);
        step2(0, 1, 32'h2FF, 0);
        step2(0, 0, 0, 0);
        chk("ovf hold err", 32'(err2), 32'd1);
        chk("ovf hold cpu_rst", 32'(cpu_rst2), 32'd1);
        chk("ovf hold cpu_run", 32'(cpu_run2), 32'd0);
        chk("ovf writes", 32'(wr_cnt2), 32'd4);
        step2(1, 0, 0, 0);
        chk("ovf reload err", 32'(err2), 32'd0);
        chk("ovf reload in_ready", 32'(bus2.in_ready), 32'd1);
        chk("ovf reload word_count", 32'(word_count2), 32'd0);
        step2(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
